// File: rtl/time_pkg.sv
// Shared BCD time definitions for the MM:SS up-count and countdown paths.
// Holds the digit limits, state encoding, field offsets and a load-validity check.
package time_pkg;

   localparam int DIGIT_W = 4;

   localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
   localparam logic [DIGIT_W-1:0] DIGIT_MAX    = 4'd9;

   // Field offsets within {min_tens, min_ones, sec_tens, sec_ones}
   localparam int SEC_ONES_LSB = 0;
   localparam int SEC_TENS_LSB = 4;
   localparam int MIN_ONES_LSB = 8;
   localparam int MIN_TENS_LSB = 12;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } time_state_t;

   function automatic logic bcd_time_valid(input logic [15:0] t);
      return (t[SEC_ONES_LSB +: DIGIT_W] <= DIGIT_MAX)    &&
             (t[SEC_TENS_LSB +: DIGIT_W] <= SEC_TENS_MAX) &&
             (t[MIN_ONES_LSB +: DIGIT_W] <= DIGIT_MAX)    &&
             (t[MIN_TENS_LSB +: DIGIT_W] <= DIGIT_MAX);
   endfunction

endpackage

// File: rtl/bcd_digit_inc.sv
// One BCD digit of an incrementer: adds carry_in, wrapping to zero past max.
// Purely combinational; chained four times for MM:SS.
module bcd_digit_inc
   import time_pkg::*;
(
   input  logic [DIGIT_W-1:0] i_digit,
   input  logic [DIGIT_W-1:0] i_max,
   input  logic               i_carry_in,
   output logic [DIGIT_W-1:0] o_next_digit,
   output logic               o_carry_out
);

   logic w_at_max;

   // >= so a digit that is somehow out of range still folds back to zero
   assign w_at_max = (i_digit >= i_max);

   always_comb begin
      o_next_digit = i_digit;
      o_carry_out  = 1'b0;
      if (i_carry_in) begin
         if (w_at_max) begin
            o_next_digit = '0;
            o_carry_out  = 1'b1;
         end else begin
            o_next_digit = i_digit + 4'd1;
         end
      end
   end

endmodule

// File: rtl/increment_time.sv
// BCD MM:SS count-up timer; stops on a programmable limit or at the 99:59 ceiling.
// Define INC_TIME_WRAP_EN to roll 99:59 over to 00:00 instead of saturating.
//
// state    | meaning
// IDLE     | stopped, waiting for start
// RUN      | counting one second per tick
// PAUSE    | stopped mid-count, ticks ignored
// DONE     | limit or ceiling reached, held until clear/load/reset
module increment_time
   import time_pkg::*;
#(
   parameter int TIME_W       = 16,
   parameter int MAX_MIN_TENS = 9
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              tick,
   input  logic              start,
   input  logic              stop,
   input  logic              clear,
   input  logic              load,
   input  logic [TIME_W-1:0] load_value,
   input  logic [TIME_W-1:0] limit,
   output logic [TIME_W-1:0] time_out,
   output logic              running,
   output logic              done,
   output logic              load_err
);

   time_state_t       r_state;
   time_state_t       w_state_nxt;
   logic [TIME_W-1:0] r_time;
   logic [TIME_W-1:0] w_time_nxt;
   logic              r_running;
   logic              r_done;
   logic              r_load_err;
   logic              w_done_nxt;
   logic              w_load_err_nxt;

   logic [TIME_W-1:0] w_inc;
   logic              w_c_so;
   logic              w_c_st;
   logic              w_c_mo;
   logic              w_ceiling;
   logic              w_load_ok;

   bcd_digit_inc u_sec_ones (
      .i_digit      (r_time[SEC_ONES_LSB +: DIGIT_W]),
      .i_max        (DIGIT_MAX),
      .i_carry_in   (1'b1),
      .o_next_digit (w_inc[SEC_ONES_LSB +: DIGIT_W]),
      .o_carry_out  (w_c_so)
   );

   bcd_digit_inc u_sec_tens (
      .i_digit      (r_time[SEC_TENS_LSB +: DIGIT_W]),
      .i_max        (SEC_TENS_MAX),
      .i_carry_in   (w_c_so),
      .o_next_digit (w_inc[SEC_TENS_LSB +: DIGIT_W]),
      .o_carry_out  (w_c_st)
   );

   bcd_digit_inc u_min_ones (
      .i_digit      (r_time[MIN_ONES_LSB +: DIGIT_W]),
      .i_max        (DIGIT_MAX),
      .i_carry_in   (w_c_st),
      .o_next_digit (w_inc[MIN_ONES_LSB +: DIGIT_W]),
      .o_carry_out  (w_c_mo)
   );

   bcd_digit_inc u_min_tens (
      .i_digit      (r_time[MIN_TENS_LSB +: DIGIT_W]),
      .i_max        (4'(MAX_MIN_TENS)),
      .i_carry_in   (w_c_mo),
      .o_next_digit (w_inc[MIN_TENS_LSB +: DIGIT_W]),
      .o_carry_out  (w_ceiling)
   );

   assign w_load_ok = bcd_time_valid(load_value) &&
                      (load_value[MIN_TENS_LSB +: DIGIT_W] <= 4'(MAX_MIN_TENS));

   always_comb begin
      w_state_nxt    = r_state;
      w_time_nxt     = r_time;
      w_done_nxt     = 1'b0;
      w_load_err_nxt = 1'b0;

      if (clear) begin
         w_time_nxt  = '0;
         w_state_nxt = ST_IDLE;
      end else if (load) begin
         if (w_load_ok) begin
            w_time_nxt  = load_value;
            w_state_nxt = ST_IDLE;
         end else begin
            w_load_err_nxt = 1'b1;
         end
      end else if (stop && (r_state == ST_RUN)) begin
         w_state_nxt = ST_PAUSE;
      end else if (start && (r_state == ST_IDLE)) begin
         // A start that finds the limit already reached is a zero-length run
         if (r_time == limit) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
         end else begin
            w_state_nxt = ST_RUN;
         end
      end else if (start && (r_state == ST_PAUSE)) begin
         w_state_nxt = ST_RUN;
      end else if (tick && (r_state == ST_RUN)) begin
         if (w_ceiling) begin
`ifdef INC_TIME_WRAP_EN
            w_time_nxt = w_inc;
            if (w_inc == limit) begin
               w_state_nxt = ST_DONE;
               w_done_nxt  = 1'b1;
            end
`else
            w_time_nxt  = r_time;
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
`endif
         end else begin
            w_time_nxt = w_inc;
            if (w_inc == limit) begin
               w_state_nxt = ST_DONE;
               w_done_nxt  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_time     <= '0;
         r_running  <= 1'b0;
         r_done     <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_time     <= w_time_nxt;
         r_running  <= (w_state_nxt == ST_RUN);
         r_done     <= w_done_nxt;
         r_load_err <= w_load_err_nxt;
      end
   end

   assign time_out = r_time;
   assign running  = r_running;
   assign done     = r_done;
   assign load_err = r_load_err;

endmodule

// File: tb/tb_increment_time.sv
// Directed vector bench for increment_time; expected values are hand-computed.
// Ceiling row expectation follows INC_TIME_WRAP_EN when defined.
module tb_increment_time;

   localparam logic [5:0] C_NONE = 6'b000000;
   localparam logic [5:0] C_RST  = 6'b100000;
   localparam logic [5:0] C_CLR  = 6'b010000;
   localparam logic [5:0] C_LD   = 6'b001000;
   localparam logic [5:0] C_STP  = 6'b000100;
   localparam logic [5:0] C_STA  = 6'b000010;
   localparam logic [5:0] C_TCK  = 6'b000001;

   typedef struct {
      logic [5:0]  cmd;
      logic [15:0] lv;
      logic [15:0] lim;
      logic [15:0] e_time;
      logic        e_run;
      logic        e_done;
      logic        e_err;
   } vec_t;

   logic        clk;
   logic        reset;
   logic        tick;
   logic        start;
   logic        stop;
   logic        clear;
   logic        load;
   logic [15:0] load_value;
   logic [15:0] limit;
   logic [15:0] time_out;
   logic        running;
   logic        done;
   logic        load_err;

   int checks = 0;
   int errors = 0;
   vec_t vecs[$];

   increment_time dut (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .start      (start),
      .stop       (stop),
      .clear      (clear),
      .load       (load),
      .load_value (load_value),
      .limit      (limit),
      .time_out   (time_out),
      .running    (running),
      .done       (done),
      .load_err   (load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [5:0] c, input logic [15:0] lv,
                               input logic [15:0] lim, input logic [15:0] et,
                               input logic er, input logic ed, input logic ee);
      vec_t v;
      v.cmd = c; v.lv = lv; v.lim = lim; v.e_time = et;
      v.e_run = er; v.e_done = ed; v.e_err = ee;
      return v;
   endfunction

   task automatic check(input string name, input int idx,
                        input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic [5:0] c, input logic [15:0] lv, input logic [15:0] lim);
      {reset, clear, load, stop, start, tick} = c;
      load_value = lv;
      limit      = lim;
   endtask

   task automatic step(input logic [5:0] c, input logic [15:0] lv, input logic [15:0] lim);
      drive(c, lv, lim);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] ceil_time;
      int done_cnt;
      int cyc;
      bit seen;

`ifdef INC_TIME_WRAP_EN
      ceil_time = 16'h0000;
`else
      ceil_time = 16'h9959;
`endif

      // cmd, load_value, limit, exp time, running, done, load_err
      vecs.push_back(mk(C_RST,  16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(C_LD,   16'h0158, 16'h0203, 16'h0158, 0, 0, 0));
      vecs.push_back(mk(C_STA,  16'h0000, 16'h0203, 16'h0158, 1, 0, 0));
      vecs.push_back(mk(C_TCK,  16'h0000, 16'h0203, 16'h0159, 1, 0, 0));
      vecs.push_back(mk(C_TCK,  16'h0000, 16'h0203, 16'h0200, 1, 0, 0));
      vecs.push_back(mk(C_TCK,  16'h0000, 16'h0203, 16'h0201, 1, 0, 0));
      vecs.push_back(mk(C_TCK,  16'h0000, 16'h0203, 16'h0202, 1, 0, 0));
      vecs.push_back(mk(C_TCK,  16'h0000, 16'h0203, 16'h0203, 0, 1, 0));
      vecs.push_back(mk(C_NONE, 16'h0000, 16'h0203, 16'h0203, 0, 0, 0));
      vecs.push_back(mk(C_TCK,  16'h0000, 16'h0203, 16'h0203, 0, 0, 0));
      vecs.push_back(mk(C_CLR,  16'h0000, 16'h0203, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(C_LD,   16'h0070, 16'h0203, 16'h0000, 0, 0, 1));
      vecs.push_back(mk(C_NONE, 16'h0000, 16'h0203, 16'h0000, 0, 0, 0));
      // pause holds the time
      vecs.push_back(mk(C_LD,   16'h0009, 16'h0100, 16'h0009, 0, 0, 0));
      vecs.push_back(mk(C_STA,  16'h0000, 16'h0100, 16'h0009, 1, 0, 0));
      vecs.push_back(mk(C_TCK,  16'h0000, 16'h0100, 16'h0010, 1, 0, 0));
      vecs.push_back(mk(C_STP,  16'h0000, 16'h0100, 16'h0010, 0, 0, 0));
      vecs.push_back(mk(C_TCK,  16'h0000, 16'h0100, 16'h0010, 0, 0, 0));
      vecs.push_back(mk(C_TCK,  16'h0000, 16'h0100, 16'h0010, 0, 0, 0));
      vecs.push_back(mk(C_TCK,  16'h0000, 16'h0100, 16'h0010, 0, 0, 0));
      vecs.push_back(mk(C_STA,  16'h0000, 16'h0100, 16'h0010, 1, 0, 0));
      vecs.push_back(mk(C_TCK,  16'h0000, 16'h0100, 16'h0011, 1, 0, 0));
      // clear beats a coincident tick
      vecs.push_back(mk(C_LD,   16'h0029, 16'h0100, 16'h0029, 0, 0, 0));
      vecs.push_back(mk(C_STA,  16'h0000, 16'h0100, 16'h0029, 1, 0, 0));
      vecs.push_back(mk(C_TCK,  16'h0000, 16'h0100, 16'h0030, 1, 0, 0));
      vecs.push_back(mk(C_CLR|C_TCK, 16'h0000, 16'h0100, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(C_TCK,  16'h0000, 16'h0100, 16'h0000, 0, 0, 0));
      // ceiling
      vecs.push_back(mk(C_LD,   16'h9959, 16'h0000, 16'h9959, 0, 0, 0));
      vecs.push_back(mk(C_STA,  16'h0000, 16'h0000, 16'h9959, 1, 0, 0));
      vecs.push_back(mk(C_TCK,  16'h0000, 16'h0000, ceil_time, 0, 1, 0));
      // reset mid-run, then zero-length run
      vecs.push_back(mk(C_LD,   16'h1233, 16'h5959, 16'h1233, 0, 0, 0));
      vecs.push_back(mk(C_STA,  16'h0000, 16'h5959, 16'h1233, 1, 0, 0));
      vecs.push_back(mk(C_TCK,  16'h0000, 16'h5959, 16'h1234, 1, 0, 0));
      vecs.push_back(mk(C_RST,  16'h0000, 16'h5959, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(C_STA,  16'h0000, 16'h0000, 16'h0000, 0, 1, 0));
      vecs.push_back(mk(C_NONE, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
      // tick on the start edge is not counted
      vecs.push_back(mk(C_LD,   16'h0100, 16'h0102, 16'h0100, 0, 0, 0));
      vecs.push_back(mk(C_STA|C_TCK, 16'h0000, 16'h0102, 16'h0100, 1, 0, 0));
      vecs.push_back(mk(C_TCK,  16'h0000, 16'h0102, 16'h0101, 1, 0, 0));
      vecs.push_back(mk(C_TCK,  16'h0000, 16'h0102, 16'h0102, 0, 1, 0));
      // illegal limit never matches
      vecs.push_back(mk(C_LD,   16'h0058, 16'h0070, 16'h0058, 0, 0, 0));
      vecs.push_back(mk(C_STA,  16'h0000, 16'h0070, 16'h0058, 1, 0, 0));
      vecs.push_back(mk(C_TCK,  16'h0000, 16'h0070, 16'h0059, 1, 0, 0));
      vecs.push_back(mk(C_TCK,  16'h0000, 16'h0070, 16'h0100, 1, 0, 0));
      // load beats start; invalid load in RUN leaves it running
      vecs.push_back(mk(C_LD,   16'hA000, 16'h0070, 16'h0100, 1, 0, 1));
      vecs.push_back(mk(C_LD|C_STA, 16'h0200, 16'h0070, 16'h0200, 0, 0, 0));
      vecs.push_back(mk(C_STP,  16'h0000, 16'h0070, 16'h0200, 0, 0, 0));

      drive(C_RST, 16'h0000, 16'h0000);
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         step(vecs[i].cmd, vecs[i].lv, vecs[i].lim);
         check("time_out", i, time_out, vecs[i].e_time);
         check("running",  i, {15'd0, running},  {15'd0, vecs[i].e_run});
         check("done",     i, {15'd0, done},     {15'd0, vecs[i].e_done});
         check("load_err", i, {15'd0, load_err}, {15'd0, vecs[i].e_err});
      end

      // Sparse ticks up to a limit of 00:05; exactly one done pulse expected
      step(C_CLR, 16'h0000, 16'h0005);
      step(C_STA, 16'h0000, 16'h0005);
      done_cnt = 0;
      seen = 0;
      cyc = 0;
      while (cyc < 100 && !seen) begin
         step((cyc % 3 == 0) ? C_TCK : C_NONE, 16'h0000, 16'h0005);
         if (done) begin
            done_cnt++;
            seen = 1;
         end
         cyc++;
      end
      check("seq_done_seen", 0, {15'd0, seen}, 16'd1);
      check("seq_time", 0, time_out, 16'h0005);
      check("seq_run", 0, {15'd0, running}, 16'd0);
      for (int k = 0; k < 6; k++) begin
         step(C_TCK, 16'h0000, 16'h0005);
         if (done) done_cnt++;
      end
      check("seq_done_count", 0, done_cnt[15:0], 16'd1);
      check("seq_time_hold", 0, time_out, 16'h0005);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
